// File: rtl/bcd_display_scanner.sv
// Multiplexed BCD-to-7-segment display scanner with per-slot blanking,
// leading-zero suppression and frame-synchronous value updates.
module bcd_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_data,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic                    lz_blank_en,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } phase_t;

    logic [SW-1:0]             slot_cnt,    slot_nxt;
    logic [DW-1:0]             digit_idx,   digit_nxt;
    logic [4*NUM_DIGITS-1:0]   active_val,  active_nxt;
    logic [4*NUM_DIGITS-1:0]   pending_val, pending_nxt;
    logic                      pending_flag, pflag_nxt;
    logic [6:0]                seg_nxt;
    logic [NUM_DIGITS-1:0]     en_nxt;
    logic                      frame_end;
    logic                      zero_run;
    logic                      cur_zero_run;
    logic [3:0]                cur_nib;
    phase_t                    phase;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // Holding the source off while a value is pending keeps frames untorn.
    assign data_ready = ~pending_flag;

    always_comb begin
        slot_nxt     = slot_cnt + SW'(1);
        digit_nxt    = digit_idx;
        active_nxt   = active_val;
        pending_nxt  = pending_val;
        pflag_nxt    = pending_flag;
        seg_nxt      = 7'b0000000;
        en_nxt       = '0;
        cur_nib      = 4'd0;
        cur_zero_run = 1'b0;
        zero_run     = 1'b1;
        frame_end    = (slot_cnt == SLOT_LAST) && (digit_idx == DIGIT_LAST);
        phase        = (slot_cnt < BLANK_END) ? BLANK : SHOW;

        if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            digit_nxt = (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DW'(1);
        end

        // A transfer can only land while nothing is pending, so it never
        // collides with the commit below; it waits for the next boundary.
        if (frame_end && pending_flag) begin
            active_nxt = pending_val;
            pflag_nxt  = 1'b0;
        end
        if (data_valid && data_ready) begin
            pending_nxt = bcd_data;
            pflag_nxt   = 1'b1;
        end

        // Scan from the most significant digit down, tracking whether every
        // nibble at or above the current position is zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (active_val[i*4 +: 4] == 4'd0);
            if (DW'(i) == digit_idx) begin
                cur_nib      = active_val[i*4 +: 4];
                cur_zero_run = zero_run;
            end
        end

        if (phase == SHOW) begin
            en_nxt = NUM_DIGITS'(1) << digit_idx;
            if (!(lz_blank_en && cur_zero_run && (digit_idx != '0)))
                seg_nxt = seg_decode(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt     <= '0;
            digit_idx    <= '0;
            active_val   <= '0;
            pending_val  <= '0;
            pending_flag <= 1'b0;
            seg_out      <= 7'b0000000;
            digit_en     <= '0;
            frame_done   <= 1'b0;
        end else begin
            slot_cnt     <= slot_nxt;
            digit_idx    <= digit_nxt;
            active_val   <= active_nxt;
            pending_val  <= pending_nxt;
            pending_flag <= pflag_nxt;
            seg_out      <= seg_nxt;
            digit_en     <= en_nxt;
            frame_done   <= frame_end;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed, table-driven bench for bcd_display_scanner with a small 4-digit,
// 8-cycle-slot configuration so that a whole frame is 32 cycles.
module tb_bcd_display_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic          clk;
    logic          rst_n;
    logic [15:0]   bcd_data;
    logic          data_valid;
    logic          data_ready;
    logic          lz_blank_en;
    logic [6:0]    seg_out;
    logic [ND-1:0] digit_en;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0]      value;
        logic             lz;
        logic [3:0][6:0]  seg;
    } vec_t;

    vec_t vecs[8];

    bcd_display_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_data   (bcd_data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .lz_blank_en(lz_blank_en),
        .seg_out    (seg_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic [15:0] value, input logic lz,
                                   input logic [6:0] s3, input logic [6:0] s2,
                                   input logic [6:0] s1, input logic [6:0] s0);
        vec_t v;
        v.value  = value;
        v.lz     = lz;
        v.seg[3] = s3;
        v.seg[2] = s2;
        v.seg[1] = s1;
        v.seg[0] = s0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Transfer one value at the current negedge; returns one cycle later.
    task automatic applyStimulus(input logic [15:0] value, input logic lz);
        checkOutput("ready_before_xfer", 32'(data_ready), 32'd1);
        lz_blank_en = lz;
        bcd_data    = value;
        data_valid  = 1'b1;
        @(negedge clk);
        data_valid  = 1'b0;
        checkOutput("ready_low_after_xfer", 32'(data_ready), 32'd0);
    endtask

    task automatic waitFrameDone();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < FRAME + 8);
        checkOutput("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    // Called at a negedge where frame_done is high; checks the next full frame.
    task automatic checkFrame(input vec_t v, input string tag);
        for (int j = 1; j <= FRAME; j++) begin
            int d;
            int s;
            logic [ND-1:0] expEn;
            logic [6:0]    expSeg;
            @(negedge clk);
            d      = (j - 1) / RD;
            s      = (j - 1) % RD;
            expEn  = (s < BC) ? '0 : ND'(1) << d;
            expSeg = (s < BC) ? 7'b0000000 : v.seg[d];
            checkOutput($sformatf("%s_en_c%0d", tag, j), 32'(digit_en), 32'(expEn));
            checkOutput($sformatf("%s_seg_c%0d", tag, j), 32'(seg_out), 32'(expSeg));
            checkOutput($sformatf("%s_fd_c%0d", tag, j), 32'(frame_done),
                        (j == FRAME) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        vec_t zeroV;
        vec_t v1111;
        vec_t v2222;
        vec_t v3333;
        int   n;

        vecs[0] = mkVec(16'h1234, 1'b0, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
        vecs[1] = mkVec(16'h0070, 1'b1, 7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110);
        vecs[2] = mkVec(16'h0000, 1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110);
        vecs[3] = mkVec(16'hA5F9, 1'b0, 7'b0000000, 7'b1011011, 7'b0000000, 7'b1111011);
        vecs[4] = mkVec(16'h0070, 1'b0, 7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110);
        vecs[5] = mkVec(16'h8600, 1'b1, 7'b1111111, 7'b1011111, 7'b1111110, 7'b1111110);
        vecs[6] = mkVec(16'h0500, 1'b1, 7'b0000000, 7'b1011011, 7'b1111110, 7'b1111110);
        vecs[7] = mkVec(16'h9876, 1'b0, 7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111);
        zeroV   = mkVec(16'h0000, 1'b0, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
        v1111   = mkVec(16'h1111, 1'b0, 7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000);
        v2222   = mkVec(16'h2222, 1'b0, 7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101);
        v3333   = mkVec(16'h3333, 1'b0, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001);

        rst_n       = 1'b0;
        bcd_data    = 16'h0000;
        data_valid  = 1'b0;
        lz_blank_en = 1'b0;
        #23;
        checkOutput("rst_seg", 32'(seg_out), 32'd0);
        checkOutput("rst_en", 32'(digit_en), 32'd0);
        checkOutput("rst_fd", 32'(frame_done), 32'd0);
        checkOutput("rst_ready", 32'(data_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_cycle_blank_en", 32'(digit_en), 32'd0);

        $display("[TB] idle frames after reset");
        waitFrameDone();
        checkFrame(zeroV, "idle0");
        checkFrame(zeroV, "idle1");
        checkOutput("idle_ready", 32'(data_ready), 32'd1);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].value, vecs[i].lz);
            waitFrameDone();
            checkOutput($sformatf("v%0d_ready_after_commit", i), 32'(data_ready), 32'd1);
            checkFrame(vecs[i], $sformatf("v%0d", i));
        end
        lz_blank_en = 1'b0;

        $display("[TB] held valid while not ready");
        bcd_data   = 16'h1111;
        data_valid = 1'b1;
        @(negedge clk);
        checkOutput("hold_ready_low", 32'(data_ready), 32'd0);
        bcd_data = 16'h2222;
        waitFrameDone();
        checkOutput("hold_ready_after_commit", 32'(data_ready), 32'd1);
        fork
            begin
                @(negedge clk);
                data_valid = 1'b0;
            end
        join_none
        checkFrame(v1111, "hold1111");
        checkFrame(v2222, "hold2222");

        $display("[TB] transfer on commit cycle");
        repeat (FRAME - 1) @(negedge clk);
        bcd_data   = 16'h3333;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        checkOutput("commit_xfer_fd", 32'(frame_done), 32'd1);
        checkOutput("commit_xfer_ready_low", 32'(data_ready), 32'd0);
        checkFrame(v2222, "commit_old");
        checkOutput("commit_xfer_ready_high", 32'(data_ready), 32'd1);
        checkFrame(v3333, "commit_new");

        $display("[TB] async reset mid-show");
        applyStimulus(16'h9999, 1'b0);
        n = 0;
        while (digit_en == '0 && n < RD) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pre_rst_show", 32'(digit_en != '0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_seg", 32'(seg_out), 32'd0);
        checkOutput("async_rst_en", 32'(digit_en), 32'd0);
        checkOutput("async_rst_ready", 32'(data_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        waitFrameDone();
        checkFrame(zeroV, "post_rst");
        checkOutput("post_rst_ready", 32'(data_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
